// File: rtl/difftest_trap_event_arbiter.sv
// difftest_trap_event_arbiter: per-core trap/WFI FIFOs drained round-robin into one registered port.
// Define DIFFTEST_TRAP_WATCHDOG_EN to add per-core stall watchdogs that inject synthetic traps.
module difftest_trap_event_arbiter #(
    parameter int NUM_CORES = 2,
    parameter int DEPTH = 4,
    parameter int CODE_W = 64,
    parameter int PC_W = 64,
    parameter int CNT_W = 64,
    parameter int ID_W = 8,
    parameter int WDOG_CYCLES = 1024,
    parameter logic [63:0] WDOG_CODE = 64'hDEAD
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        in_valid,
    input  logic [NUM_CORES-1:0]        in_hasTrap,
    input  logic [NUM_CORES-1:0]        in_hasWFI,
    input  logic [NUM_CORES*CODE_W-1:0] in_code,
    input  logic [NUM_CORES*PC_W-1:0]   in_pc,
    input  logic [NUM_CORES*CNT_W-1:0]  in_instrCnt,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_hasTrap,
    output logic                        out_hasWFI,
    output logic [CODE_W-1:0]           out_code,
    output logic [PC_W-1:0]             out_pc,
    output logic [CNT_W-1:0]            out_instrCnt,
    output logic [CNT_W-1:0]            out_cycleCnt,
    output logic [ID_W-1:0]             out_coreid,
    output logic [NUM_CORES-1:0]        trapped,
    output logic [NUM_CORES-1:0]        overflow,
    output logic                        drained
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;

    typedef struct packed {
        logic              trap;
        logic              wfi;
        logic [CODE_W-1:0] code;
        logic [PC_W-1:0]   pc;
        logic [CNT_W-1:0]  icnt;
        logic [CNT_W-1:0]  ccnt;
    } ev_t;

    function automatic int wrap(input int a);
        return a >= NUM_CORES ? a - NUM_CORES : a;
    endfunction

    logic [CNT_W-1:0]     cnt_q;
    logic [NUM_CORES-1:0] trapped_q, trapped_d, overflow_q, overflow_d;
    logic [NUM_CORES-1:0] empty, pop;
    logic [RW-1:0]        rr_q, rr_d, gidx;
    logic                 grant, can_load, out_valid_q, drained_q;
    logic [ID_W-1:0]      out_id_q;
    ev_t                  heads [NUM_CORES];
    ev_t                  out_q;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
        ev_t              mem_q [DEPTH];
        ev_t              ev;
        logic [AW:0]      wr_q, rd_q;
        logic [CNT_W-1:0] icnt;
        logic             wd_fire, ev_v, full, take;
        assign icnt = in_instrCnt[g*CNT_W +: CNT_W];
`ifdef DIFFTEST_TRAP_WATCHDOG_EN
        logic [31:0]      stall_q;
        logic [CNT_W-1:0] prev_q;
        logic             at_limit;
        assign at_limit = stall_q == 32'(WDOG_CYCLES - 1);
        assign wd_fire  = at_limit && !trapped_q[g] && !in_valid[g];
        always_ff @(posedge clock) begin
            if (reset) begin
                stall_q <= '0;
                prev_q  <= '0;
            end else begin
                prev_q  <= icnt;
                stall_q <= (trapped_q[g] || icnt != prev_q || (in_valid[g] && at_limit)) ? '0 : stall_q + 32'd1;
            end
        end
`else
        assign wd_fire = 1'b0;
`endif
        assign ev = wd_fire ? '{1'b1, 1'b0, CODE_W'(WDOG_CODE), in_pc[g*PC_W +: PC_W], icnt, cnt_q}
                            : '{in_hasTrap[g], in_hasWFI[g], in_code[g*CODE_W +: CODE_W], in_pc[g*PC_W +: PC_W], icnt, cnt_q};
        assign ev_v     = (in_valid[g] || wd_fire) && !trapped_q[g];
        assign empty[g] = wr_q == rd_q;
        assign full     = wr_q[AW] != rd_q[AW] && wr_q[AW-1:0] == rd_q[AW-1:0];
        assign take     = ev_v && (!full || pop[g]);
        assign heads[g] = mem_q[rd_q[AW-1:0]];
        assign trapped_d[g]  = trapped_q[g] || (ev_v && ev.trap);
        assign overflow_d[g] = overflow_q[g] || (ev_v && !take);
        always_ff @(posedge clock) begin
            if (reset) begin
                wr_q <= '0;
                rd_q <= '0;
            end else begin
                if (take) mem_q[wr_q[AW-1:0]] <= ev;
                wr_q <= wr_q + (AW+1)'(take);
                rd_q <= rd_q + (AW+1)'(pop[g]);
            end
        end
    end

    // First non-empty FIFO at or after the round-robin pointer
    always_comb begin
        grant = 1'b0;
        gidx  = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (!grant && !empty[wrap(int'(rr_q) + k)]) begin
                grant = 1'b1;
                gidx  = RW'(wrap(int'(rr_q) + k));
            end
        end
    end

    assign can_load = !out_valid_q || out_ready;
    assign pop      = NUM_CORES'(grant && can_load) << gidx;
    assign rr_d     = (grant && can_load) ? RW'(wrap(int'(gidx) + 1)) : rr_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q       <= '0;
            rr_q        <= '0;
            trapped_q   <= '0;
            overflow_q  <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_id_q    <= '0;
            drained_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_q + CNT_W'(1);
            rr_q       <= rr_d;
            trapped_q  <= trapped_d;
            overflow_q <= overflow_d;
            drained_q  <= &trapped_q && &empty && !out_valid_q;
            if (can_load) out_valid_q <= grant;
            if (can_load && grant) begin
                out_q    <= heads[gidx];
                out_id_q <= ID_W'(gidx);
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_hasTrap  = out_q.trap;
    assign out_hasWFI   = out_q.wfi;
    assign out_code     = out_q.code;
    assign out_pc       = out_q.pc;
    assign out_instrCnt = out_q.icnt;
    assign out_cycleCnt = out_q.ccnt;
    assign out_coreid   = out_id_q;
    assign trapped      = trapped_q;
    assign overflow     = overflow_q;
    assign drained      = drained_q;
endmodule

// File: tb/tb_difftest_trap_event_arbiter.sv
// tb_difftest_trap_event_arbiter: directed vectors for capture, round-robin, backpressure, sticky trap and reset.
module tb_difftest_trap_event_arbiter;
    logic         clock = 1'b0;
    logic         reset;
    logic [1:0]   in_valid, in_hasTrap, in_hasWFI;
    logic [127:0] in_code, in_pc, in_instrCnt;
    logic         out_valid, out_ready, out_hasTrap, out_hasWFI, drained;
    logic [63:0]  out_code, out_pc, out_instrCnt, out_cycleCnt;
    logic [7:0]   out_coreid;
    logic [1:0]   trapped, overflow;
    int           checks = 0;
    int           failures = 0;

    typedef struct {
        logic [1:0]  v;
        logic [63:0] c0, c1;
        logic        ev;
        logic [7:0]  eid;
        logic [63:0] ecode, ecc;
    } vec_t;
    vec_t tbl [8];

    difftest_trap_event_arbiter dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_hasTrap(in_hasTrap),
        .in_hasWFI(in_hasWFI), .in_code(in_code), .in_pc(in_pc), .in_instrCnt(in_instrCnt),
        .out_valid(out_valid), .out_ready(out_ready), .out_hasTrap(out_hasTrap),
        .out_hasWFI(out_hasWFI), .out_code(out_code), .out_pc(out_pc),
        .out_instrCnt(out_instrCnt), .out_cycleCnt(out_cycleCnt), .out_coreid(out_coreid),
        .trapped(trapped), .overflow(overflow), .drained(drained)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", n, a, e);
        end
    endtask

    task automatic clear_in();
        in_valid = '0;
        in_hasTrap = '0;
        in_hasWFI = '0;
    endtask

    task automatic drive(input int c, input logic t, input logic w, input logic [63:0] code);
        in_valid[c] = 1'b1;
        in_hasTrap[c] = t;
        in_hasWFI[c] = w;
        in_code[c*64 +: 64] = code;
        in_pc[c*64 +: 64] = 64'h8000_0000 + code;
        in_instrCnt[c*64 +: 64] = code + 64'd1;
    endtask

    task automatic do_reset();
        clear_in();
        out_ready = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        tbl[0] = '{2'b11, 64'h10, 64'h20, 1'b0, 8'd0, 64'h0,  64'd0};
        tbl[1] = '{2'b11, 64'h11, 64'h21, 1'b1, 8'd0, 64'h10, 64'd0};
        tbl[2] = '{2'b11, 64'h12, 64'h22, 1'b1, 8'd1, 64'h20, 64'd0};
        tbl[3] = '{2'b00, 64'h0,  64'h0,  1'b1, 8'd0, 64'h11, 64'd1};
        tbl[4] = '{2'b00, 64'h0,  64'h0,  1'b1, 8'd1, 64'h21, 64'd1};
        tbl[5] = '{2'b00, 64'h0,  64'h0,  1'b1, 8'd0, 64'h12, 64'd2};
        tbl[6] = '{2'b00, 64'h0,  64'h0,  1'b1, 8'd1, 64'h22, 64'd2};
        tbl[7] = '{2'b00, 64'h0,  64'h0,  1'b0, 8'd0, 64'h0,  64'd0};
        in_code = '0;
        in_pc = '0;
        in_instrCnt = '0;

        do_reset();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_code", out_code, 64'd0);
        chk("rst_cycle", out_cycleCnt, 64'd0);
        chk("rst_trapped", 64'(trapped), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drained", 64'(drained), 64'd0);

        // single trap on core0 at cycle 5
        repeat (5) tick();
        drive(0, 1'b1, 1'b0, 64'h0);
        tick();
        clear_in();
        chk("single_early_valid", 64'(out_valid), 64'd0);
        chk("single_trapped", 64'(trapped), 64'd1);
        tick();
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_cycle", out_cycleCnt, 64'd5);
        chk("single_id", 64'(out_coreid), 64'd0);
        chk("single_pc", out_pc, 64'h8000_0000);
        chk("single_trap", 64'(out_hasTrap), 64'd1);
        out_ready = 1'b1;
        tick();
        chk("single_after_valid", 64'(out_valid), 64'd0);
        tick();
        chk("single_drained", 64'(drained), 64'd0);

        // round-robin vectors
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            clear_in();
            if (tbl[i].v[0]) drive(0, 1'b0, 1'b1, tbl[i].c0);
            if (tbl[i].v[1]) drive(1, 1'b0, 1'b1, tbl[i].c1);
            tick();
            chk($sformatf("rr%0d_valid", i), 64'(out_valid), 64'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("rr%0d_id", i), 64'(out_coreid), 64'(tbl[i].eid));
                chk($sformatf("rr%0d_code", i), out_code, tbl[i].ecode);
                chk($sformatf("rr%0d_cycle", i), out_cycleCnt, tbl[i].ecc);
                chk($sformatf("rr%0d_wfi", i), 64'(out_hasWFI), 64'd1);
            end
        end
        clear_in();

        // backpressure and overflow on core1
        do_reset();
        for (int n = 0; n < 6; n++) begin
            clear_in();
            drive(1, 1'b0, 1'b1, 64'h30 + 64'(n));
            tick();
        end
        clear_in();
        chk("bp_overflow", 64'(overflow), 64'h2);
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_code", out_code, 64'h30);
        tick();
        tick();
        chk("bp_hold_code", out_code, 64'h30);
        chk("bp_hold_id", 64'(out_coreid), 64'd1);
        out_ready = 1'b1;
        for (int n = 1; n < 5; n++) begin
            tick();
            chk($sformatf("bp_drain%0d", n), out_code, 64'h30 + 64'(n));
            chk($sformatf("bp_drain%0d_valid", n), 64'(out_valid), 64'd1);
        end
        tick();
        chk("bp_empty", 64'(out_valid), 64'd0);

        // sticky trap then drained
        do_reset();
        out_ready = 1'b1;
        drive(0, 1'b1, 1'b0, 64'h55);
        tick();
        chk("sticky_trapped", 64'(trapped), 64'd1);
        clear_in();
        drive(0, 1'b0, 1'b1, 64'h56);
        tick();
        chk("sticky_out", out_code, 64'h55);
        chk("sticky_out_trap", 64'(out_hasTrap), 64'd1);
        clear_in();
        drive(0, 1'b0, 1'b1, 64'h57);
        tick();
        clear_in();
        chk("sticky_no_more", 64'(out_valid), 64'd0);
        chk("sticky_overflow", 64'(overflow), 64'd0);
        drive(1, 1'b1, 1'b0, 64'h66);
        tick();
        clear_in();
        tick();
        chk("sticky_core1", out_code, 64'h66);
        chk("sticky_not_drained", 64'(drained), 64'd0);
        for (int k = 0; k < 10 && !drained; k++) tick();
        chk("sticky_drained", 64'(drained), 64'd1);
        chk("sticky_trapped_all", 64'(trapped), 64'h3);

        // reset with events buffered
        do_reset();
        drive(0, 1'b0, 1'b1, 64'h1);
        drive(1, 1'b1, 1'b0, 64'h2);
        tick();
        clear_in();
        drive(0, 1'b0, 1'b1, 64'h3);
        tick();
        drive(0, 1'b0, 1'b1, 64'h4);
        tick();
        clear_in();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_valid", 64'(out_valid), 64'd0);
        chk("mid_trapped", 64'(trapped), 64'd0);
        out_ready = 1'b1;
        drive(0, 1'b0, 1'b1, 64'h7);
        tick();
        clear_in();
        tick();
        chk("mid_new_valid", 64'(out_valid), 64'd1);
        chk("mid_new_code", out_code, 64'h7);
        chk("mid_new_cycle", out_cycleCnt, 64'd0);
        tick();
        chk("mid_no_stale", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
